// File: rtl/pc_gen_ras.sv
// pc_gen_ras: program counter with branch/jump/JR selection, stall, exception redirect and return-address stack
module pc_gen_ras #(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter int          RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              exc,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] sext_immed,
    input  logic [25:0]       jump_addr,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic              is_call,
    input  logic              is_ret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              ras_hit,
    output logic              ras_empty,
    output logic              ras_full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VECTOR);
    localparam logic [ADDR_W-1:0] HI_MASK = ~ADDR_W'(28'hFFF_FFFF);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]     top;
    logic [PW-1:0]     top_up;
    logic [PW:0]       count;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] jump_target;
    logic              push;
    logic              pop;

    assign pc_plus4    = pc + ADDR_W'(4);
    assign jump_target = (pc & HI_MASK) | ADDR_W'({jump_addr, 2'b00});
    assign top_up      = top + PW'(1);
    assign ras_empty   = count == '0;
    assign ras_full    = count == FULL_CNT;

    // next-PC selection; a RAS hit needs a qualified return with a non-empty stack and no exception
    always_comb begin
        ras_hit = !exc && pc_src == 2'b11 && is_ret && !ras_empty;
        next_pc = exc            ? EXC_PC :
                  pc_src == 2'b00 ? pc_plus4 :
                  pc_src == 2'b01 ? pc + sext_immed :
                  pc_src == 2'b10 ? jump_target :
                  ras_hit         ? ras[top] : alu_out;
        push    = !stall && !exc && pc_src == 2'b10 && is_call;
        pop     = !stall && ras_hit;
    end

    // architectural PC: exception beats stall, stall holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RST_PC;
        else if (exc)
            pc <= EXC_PC;
        else if (!stall)
            pc <= next_pc;
    end

    // circular return stack: push overwrites the oldest entry when full, exception flushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top   <= '0;
            count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                ras[i] <= '0;
        end else if (exc) begin
            top   <= '0;
            count <= '0;
        end else if (push) begin
            ras[top_up] <= pc_plus4;
            top         <= top_up;
            count       <= ras_full ? count : count + 1'b1;
        end else if (pop) begin
            top   <= top - PW'(1);
            count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_pc_gen_ras.sv
// tb_pc_gen_ras: directed scenario tests for pc_gen_ras
module tb_pc_gen_ras;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        exc;
    logic [1:0]  pc_src;
    logic [31:0] sext_immed;
    logic [25:0] jump_addr;
    logic [31:0] alu_out;
    logic        is_call;
    logic        is_ret;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        ras_hit;
    logic        ras_empty;
    logic        ras_full;

    int n_cmp = 0;
    int n_err = 0;

    pc_gen_ras dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .exc(exc), .pc_src(pc_src),
        .sext_immed(sext_immed), .jump_addr(jump_addr), .alu_out(alu_out),
        .is_call(is_call), .is_ret(is_ret), .pc(pc), .next_pc(next_pc),
        .ras_hit(ras_hit), .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    task automatic idle();
        stall = 0; exc = 0; pc_src = 2'b00; sext_immed = 0;
        jump_addr = 0; alu_out = 0; is_call = 0; is_ret = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] a);
        idle();
        pc_src = 2'b11; alu_out = a;
        step();
        idle();
    endtask

    task automatic call_from(input logic [31:0] a, input logic [25:0] ja);
        set_pc(a);
        pc_src = 2'b10; is_call = 1; jump_addr = ja;
        step();
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        idle();
        rst_n = 0;
        #3;
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", ras_empty); end
        n_cmp++; if (ras_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", ras_full); end
        step();
        step();
        rst_n = 1;
        exp_pc = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_pc += 4;
            n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, exp_pc); end
        end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL seq_empty: got %b want 1", ras_empty); end
    endtask

    task automatic test_branch_jump();
        set_pc(32'h10);
        pc_src = 2'b01; sext_immed = 32'hFFFF_FFF8;
        #1;
        n_cmp++; if (next_pc !== 32'h8) begin n_err++; $display("FAIL branch_next: got %h want %h", next_pc, 32'h8); end
        step();
        n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL branch_pc: got %h want %h", pc, 32'h8); end
        set_pc(32'h3000_0000);
        pc_src = 2'b10; jump_addr = 26'h40;
        step();
        n_cmp++; if (pc !== 32'h3000_0100) begin n_err++; $display("FAIL jump_pc: got %h want %h", pc, 32'h3000_0100); end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL jump_no_push: got %b want 1", ras_empty); end
        idle();
    endtask

    task automatic test_call_return();
        call_from(32'h100, 26'h80);
        n_cmp++; if (pc !== 32'h200) begin n_err++; $display("FAIL call_pc: got %h want %h", pc, 32'h200); end
        n_cmp++; if (ras_empty !== 1'b0) begin n_err++; $display("FAIL call_empty: got %b want 0", ras_empty); end
        pc_src = 2'b11; is_ret = 1; alu_out = 32'hDEAD_0000;
        #1;
        n_cmp++; if (ras_hit !== 1'b1) begin n_err++; $display("FAIL ret_hit: got %b want 1", ras_hit); end
        n_cmp++; if (next_pc !== 32'h104) begin n_err++; $display("FAIL ret_next: got %h want %h", next_pc, 32'h104); end
        step();
        n_cmp++; if (pc !== 32'h104) begin n_err++; $display("FAIL ret_pc: got %h want %h", pc, 32'h104); end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ret_empty: got %b want 1", ras_empty); end
        n_cmp++; if (ras_hit !== 1'b0) begin n_err++; $display("FAIL ret_empty_hit: got %b want 0", ras_hit); end
        n_cmp++; if (next_pc !== 32'hDEAD_0000) begin n_err++; $display("FAIL ret_empty_next: got %h want %h", next_pc, 32'hDEAD_0000); end
        idle();
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ret [4] = '{32'h54, 32'h44, 32'h34, 32'h24};
        for (int i = 1; i <= 5; i++) begin
            call_from(32'(i * 16), 26'h100);
            n_cmp++; if (ras_full !== (i >= 4)) begin n_err++; $display("FAIL ovf_full[%0d]: got %b want %b", i, ras_full, i >= 4); end
        end
        for (int i = 0; i < 4; i++) begin
            pc_src = 2'b11; is_ret = 1; alu_out = 32'hBAD0;
            #1;
            n_cmp++; if (ras_hit !== 1'b1) begin n_err++; $display("FAIL ovf_hit[%0d]: got %b want 1", i, ras_hit); end
            n_cmp++; if (next_pc !== exp_ret[i]) begin n_err++; $display("FAIL ovf_next[%0d]: got %h want %h", i, next_pc, exp_ret[i]); end
            step();
            n_cmp++; if (pc !== exp_ret[i]) begin n_err++; $display("FAIL ovf_pc[%0d]: got %h want %h", i, pc, exp_ret[i]); end
            n_cmp++; if (ras_full !== 1'b0) begin n_err++; $display("FAIL ovf_notfull[%0d]: got %b want 0", i, ras_full); end
        end
        n_cmp++; if (ras_hit !== 1'b0) begin n_err++; $display("FAIL unf_hit: got %b want 0", ras_hit); end
        n_cmp++; if (next_pc !== 32'hBAD0) begin n_err++; $display("FAIL unf_next: got %h want %h", next_pc, 32'hBAD0); end
        step();
        n_cmp++; if (pc !== 32'hBAD0) begin n_err++; $display("FAIL unf_pc: got %h want %h", pc, 32'hBAD0); end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL unf_empty: got %b want 1", ras_empty); end
        idle();
    endtask

    task automatic test_stall_exc();
        call_from(32'h40, 26'h20);
        n_cmp++; if (pc !== 32'h80) begin n_err++; $display("FAIL se_call_pc: got %h want %h", pc, 32'h80); end
        stall = 1; pc_src = 2'b10; is_call = 1; jump_addr = 26'h300;
        #1;
        n_cmp++; if (next_pc !== 32'hC00) begin n_err++; $display("FAIL stall_next: got %h want %h", next_pc, 32'hC00); end
        step();
        n_cmp++; if (pc !== 32'h80) begin n_err++; $display("FAIL stall_pc: got %h want %h", pc, 32'h80); end
        idle();
        pc_src = 2'b11; is_ret = 1; alu_out = 32'h1234;
        #1;
        n_cmp++; if (next_pc !== 32'h44) begin n_err++; $display("FAIL stall_ras_top: got %h want %h", next_pc, 32'h44); end
        exc = 1; stall = 1;
        #1;
        n_cmp++; if (ras_hit !== 1'b0) begin n_err++; $display("FAIL exc_hit: got %b want 0", ras_hit); end
        n_cmp++; if (next_pc !== 32'h180) begin n_err++; $display("FAIL exc_next: got %h want %h", next_pc, 32'h180); end
        step();
        n_cmp++; if (pc !== 32'h180) begin n_err++; $display("FAIL exc_pc: got %h want %h", pc, 32'h180); end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL exc_empty: got %b want 1", ras_empty); end
        idle();
    endtask

    task automatic test_async_reset();
        call_from(32'h10, 26'h4);
        call_from(32'h10, 26'h4);
        set_pc(32'h40);
        n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL ar_pre_pc: got %h want %h", pc, 32'h40); end
        n_cmp++; if (ras_empty !== 1'b0) begin n_err++; $display("FAIL ar_pre_empty: got %b want 0", ras_empty); end
        #2;
        rst_n = 0;
        #1;
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL ar_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ar_empty: got %b want 1", ras_empty); end
        step();
        rst_n = 1;
        step();
        n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL ar_resume: got %h want %h", pc, 32'h4); end
    endtask

    initial begin
        test_reset();
        test_branch_jump();
        test_call_return();
        test_ras_overflow();
        test_stall_exc();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
- Parametrised next-generation PC generator. Holds the architectural PC register and selects the next PC from sequential, branch, jump and jump-register sources.
- Adds stall, exception redirect and a circular return-address stack (RAS) that predicts `jr $ra` targets.
- Sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
- ADDR_W, 32, PC/address width; must be >= 28.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (lower ADDR_W bits used).
- EXC_VECTOR, 32'h0000_0180, PC loaded on exception (lower ADDR_W bits used).
- RAS_DEPTH, 4, number of RAS entries; must be a power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and RAS when 1.
- exc  in  1  exception redirect; overrides stall and pc_src.
- pc_src  in  2  00 sequential, 01 branch, 10 jump, 11 jump-register.
- sext_immed  in  ADDR_W  sign-extended byte offset for branch.
- jump_addr  in  26  J-type target field.
- alu_out  in  ADDR_W  register-sourced JR target.
- is_call  in  1  current jump is a call (jal); qualified by pc_src==10.
- is_ret  in  1  current JR is a return; qualified by pc_src==11.
- pc  out  ADDR_W  registered current PC.
- next_pc  out  ADDR_W  combinational next PC.
- ras_hit  out  1  combinational; 1 when next_pc is taken from the RAS.
- ras_empty  out  1  registered-state flag: RAS count == 0.
- ras_full  out  1  registered-state flag: RAS count == RAS_DEPTH.

Behaviour:
- Reset is asynchronous and active-low:
  - On rst_n=0: pc=RESET_PC, RAS count=0, top pointer=0, all entries=0.
  - Resulting outputs: ras_empty=1, ras_full=0.
  - Reset release is synchronous to clk.
- next_pc selection (combinational), in priority order:
  1. exc=1 -> EXC_VECTOR.
  2. pc_src 00 -> pc+4.
  3. pc_src 01 -> pc+sext_immed. Offset is relative to the current pc, with no +4. Arithmetic is modulo 2^ADDR_W.
  4. pc_src 10 -> {pc[ADDR_W-1:28], jump_addr, 2'b00}.
  5. pc_src 11 with is_ret=1 and RAS non-empty -> RAS top entry, ras_hit=1.
  6. pc_src 11 otherwise -> alu_out.
- ras_hit is 0 in every case except item 5, including whenever exc=1.
- next_pc is reported even while stall=1. It is not committed during a stall.
- PC update on the rising edge:
  - exc=1 -> pc<=EXC_VECTOR.
  - else stall=0 -> pc<=next_pc.
  - else pc holds.
- Latency: a redirect presented in cycle N appears on pc in cycle N+1.
- RAS push, when commit (stall=0, exc=0) and pc_src==10 and is_call=1:
  - Write pc+4 at top+1 and advance top.
  - Count increments, saturating at RAS_DEPTH.
  - When full, the push overwrites the oldest entry (circular) and ras_full stays 1.
- RAS pop, when commit and pc_src==11 and is_ret=1:
  - If count>0: decrement top and count.
  - If count==0: no state change; target comes from alu_out.
- Push and pop are mutually exclusive by pc_src encoding. is_call is ignored when pc_src!=10; is_ret is ignored when pc_src!=11.
- stall=1 and exc=0: no push, no pop, pc holds.
- exc=1: flush the RAS (count=0, top=0; entry contents are don't-care). No push or pop that cycle, regardless of stall.
- Reset asserted mid-operation: immediate return to reset state, no waiting for a clock edge.
- Overflow-then-underflow: after RAS_DEPTH+k pushes, only the last RAS_DEPTH returns hit. Any further return falls back to alu_out.

Test Plan:
1. Reset and sequential fetch: hold rst_n=0, then release with pc_src=00 for 3 cycles -> pc = 0x0, 0x4, 0x8, 0xC; ras_empty=1.
2. Branch and jump: at pc=0x0000_0010, sext_immed=0xFFFF_FFF8 with pc_src=01 -> pc=0x0000_0008. At pc=0x3000_0000, jump_addr=0x0000040, pc_src=10 -> pc=0x3000_0100.
3. Call/return pairing: jal at pc=0x100 with jump_addr=0x80 -> pc=0x200 and RAS top=0x104. Then pc_src=11, is_ret=1, alu_out=0xDEAD0000 -> ras_hit=1, next pc=0x104, ras_empty=1.
4. RAS overflow (RAS_DEPTH=4): 5 calls from pc=0x10, 0x20, 0x30, 0x40, 0x50 -> ras_full=1. Then 5 returns give 0x54, 0x44, 0x34, 0x24, and the 5th takes alu_out with ras_hit=0.
5. Stall and exception priority:
   - stall=1 with pc_src=10, is_call=1 -> pc and RAS unchanged.
   - exc=1 with stall=1 -> pc=0x180 next cycle, ras_empty=1.
6. Asynchronous reset mid-run: drop rst_n between clock edges while pc=0x40 and count=2 -> pc=0x0 and ras_empty=1 immediately, without a clock edge.
